// File: rtl/core_loader_pkg.sv
// core_loader_pkg
//   Shared definitions for the core boot/run controller: command opcodes,
//   FSM state encoding, command-word field positions and a small decode
//   helper.
//   Handshake (used by every stream port of core_loader): a word moves when
//   valid and ready are both high at a rising clock edge; valid may not be
//   withdrawn by the producer before acceptance, ready may change freely.
package core_loader_pkg;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_LOAD_INSN = 4'd1,
        OP_LOAD_DATA = 4'd2,
        OP_RUN       = 4'd3,
        OP_HALT      = 4'd4
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RST   = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    // Command word layout: opcode in the top nibble, argument below it.
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int ARG_W   = 28;
    localparam int LIMIT_W = 24;

    function automatic logic [3:0] cmd_opcode(input logic [31:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/core_loader.sv
// core_loader
//   Host-facing boot and run controller. Consumes a 32-bit command/payload
//   stream, writes instruction or data memory through the core's load port,
//   then pulses the core reset and lets the core run for a commanded number
//   of cycles (or until HALT).
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset of this block
//   in_data     command or payload word
//   in_valid    host word valid
//   in_ready    word accepted when in_valid & in_ready at a rising edge
//   core_reset  active-high reset to the core
//   core_run    run enable to the core
//   insn_addr/insn_din/insn_we  instruction write port (byte address)
//   data_addr/data_din/data_we  data write port (byte address)
//   busy        FSM is not in IDLE
//   err         sticky error flag, cleared by NOP
//   fsm_state   current FSM state (state_t encoding) for observation
//
// Every output is a register; next-state is computed combinationally so
// that ready/busy/run/reset can be registered from it and line up with the
// state they describe.
module core_loader
    import core_loader_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        core_reset,
    output logic        core_run,
    output logic [31:0] insn_addr,
    output logic [31:0] insn_din,
    output logic        insn_we,
    output logic [31:0] data_addr,
    output logic [31:0] data_din,
    output logic        data_we,
    output logic        busy,
    output logic        err,
    output logic [2:0]  fsm_state
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_ADDR  = ST_ADDR;
    localparam logic [2:0] S_WRITE = ST_WRITE;
    localparam logic [2:0] S_RST   = ST_RST;
    localparam logic [2:0] S_RUN   = ST_RUN;

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic               sel_data;   // port latched at LOAD decode
    logic [CNT_W-1:0]   remaining;  // payload words still to come
    logic [31:0]        addr;       // address of the next payload word
    logic [RST_W-1:0]   rst_cnt;    // core reset cycles still to hold
    logic [LIMIT_W-1:0] run_cnt;    // run cycles left, valid when limit_on
    logic               limit_on;

    logic [3:0] opcode;
    logic       accept;

    assign opcode    = cmd_opcode(in_data);
    assign accept    = in_valid & in_ready;
    assign fsm_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (opcode == OP_LOAD_INSN || opcode == OP_LOAD_DATA)
                        state_nxt = S_ADDR;
                    else if (opcode == OP_RUN)
                        state_nxt = S_RST;
                end
            end
            S_ADDR: begin
                if (accept)
                    state_nxt = (remaining == '0) ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                if (accept && remaining == CNT_W'(1))
                    state_nxt = S_IDLE;
            end
            S_RST: begin
                if (rst_cnt == '0)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                // HALT and limit expiry in the same cycle collapse into one stop.
                if ((accept && opcode == OP_HALT) ||
                    (limit_on && run_cnt == LIMIT_W'(1)))
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            core_reset <= 1'b1;
            core_run   <= 1'b0;
            insn_addr  <= '0;
            insn_din   <= '0;
            insn_we    <= 1'b0;
            data_addr  <= '0;
            data_din   <= '0;
            data_we    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            sel_data   <= 1'b0;
            remaining  <= '0;
            addr       <= '0;
            rst_cnt    <= '0;
            run_cnt    <= '0;
            limit_on   <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != S_IDLE);
            in_ready <= (state_nxt != S_RST);
            core_run <= (state_nxt == S_RUN);
            // Core stays in reset from power-up until its first run; once a
            // run has started, reset is only reasserted by the next RUN.
            core_reset <= (state_nxt == S_RST) | (core_reset & (state_nxt != S_RUN));
            insn_we  <= 1'b0;
            data_we  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (opcode)
                            OP_NOP: err <= 1'b0;
                            OP_LOAD_INSN, OP_LOAD_DATA: begin
                                sel_data  <= (opcode == OP_LOAD_DATA);
                                remaining <= in_data[CNT_W-1:0];
                            end
                            OP_RUN: begin
                                run_cnt  <= in_data[LIMIT_W-1:0];
                                limit_on <= |in_data[LIMIT_W-1:0];
                                rst_cnt  <= RST_W'(RST_CYCLES - 1);
                            end
                            OP_HALT: begin
                                // No-op outside RUN.
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (accept)
                        addr <= in_data;
                end
                S_WRITE: begin
                    if (accept) begin
                        if (sel_data) begin
                            data_we   <= 1'b1;
                            data_addr <= addr;
                            data_din  <= in_data;
                        end else begin
                            insn_we   <= 1'b1;
                            insn_addr <= addr;
                            insn_din  <= in_data;
                        end
                        addr      <= addr + 32'd4;
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                S_RST: begin
                    if (rst_cnt != '0)
                        rst_cnt <= rst_cnt - RST_W'(1);
                end
                S_RUN: begin
                    // Every word is consumed here; only HALT is legal.
                    if (accept && opcode != OP_HALT)
                        err <= 1'b1;
                    if (limit_on)
                        run_cnt <= run_cnt - LIMIT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_loader.sv
module tb_core_loader;
    import core_loader_pkg::*;

    localparam int W     = 65;   // {port, addr, data}
    localparam int RST_N = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, core_reset, core_run;
    logic [31:0] insn_addr, insn_din, data_addr, data_din;
    logic        insn_we, data_we, busy, err;
    logic [2:0]  fsm_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    core_loader #(.RST_CYCLES(RST_N), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .core_reset(core_reset), .core_run(core_run),
        .insn_addr(insn_addr), .insn_din(insn_din), .insn_we(insn_we),
        .data_addr(data_addr), .data_din(data_din), .data_we(data_we),
        .busy(busy), .err(err), .fsm_state(fsm_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int we_cyc[$];

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (insn_we || data_we) begin
            we_cyc.push_back(cyc);
            if (insn_we && data_we) begin
                n_checks++; n_fail++;
                $display("FAIL both_we: got both strobes high expected one");
            end else if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_write: got write port=%0d addr=%0h expected none",
                         data_we, data_we ? data_addr : insn_addr);
            end else begin
                logic [W-1:0] e;
                logic [W-1:0] g;
                e = exp_q.pop_front();
                g = data_we ? {1'b1, data_addr, data_din} : {1'b0, insn_addr, insn_din};
                check("write", 96'(g), 96'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after acceptance with
    // in_valid still high so bursts run at one word per clock.
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        @(negedge clk);
    endtask

    task automatic send_payload(input logic port, input logic [31:0] a, input logic [31:0] w);
        exp_q.push_back({port, a, w});
        send_word(w);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   in_ready,   0);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_core_run"},   core_run,   0);
        check({tag, "_strobes"},    {insn_we, data_we}, 0);
        check({tag, "_addrs_din"},  {insn_addr, insn_din, data_addr}, 0);
        check({tag, "_data_din"},   data_din,   0);
        check({tag, "_busy_err"},   {busy, err}, 0);
        check({tag, "_state"},      fsm_state,  ST_IDLE);
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [31:0] cmd;
        logic        exp_err;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int bad_rst, bad_run, bad_rdy, run_seen;
        logic exp_r, exp_u;

        vecs[0] = '{32'h7000_0000, 1'b1, 1'b0};   // illegal opcode
        vecs[1] = '{32'h0000_0000, 1'b0, 1'b0};   // NOP clears
        vecs[2] = '{32'hF123_4567, 1'b1, 1'b0};
        vecs[3] = '{32'h4000_0000, 1'b1, 1'b0};   // HALT in IDLE: no-op, err kept
        vecs[4] = '{32'h0ABC_DEF0, 1'b0, 1'b0};   // NOP with argument
        vecs[5] = '{32'h5000_0001, 1'b1, 1'b0};
        vecs[6] = '{32'h4000_0000, 1'b1, 1'b0};
        vecs[7] = '{32'h0000_0000, 1'b0, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_release", in_ready, 1);
        check("busy_after_release", busy, 0);

        // table-driven command decode in IDLE
        for (int i = 0; i < 8; i++) begin
            send_word(vecs[i].cmd);
            idle();
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_state", i), fsm_state, ST_IDLE);
        end

        // LOAD_INSN N=3 base 0x100, back-to-back payload
        we_cyc.delete();
        send_word(32'h1000_0003);
        check("load_insn_busy", busy, 1);
        send_word(32'h0000_0100);
        send_payload(1'b0, 32'h100, 32'hAAAA_0001);
        send_payload(1'b0, 32'h104, 32'hBBBB_0002);
        send_payload(1'b0, 32'h108, 32'hCCCC_0003);
        idle();
        repeat (3) @(negedge clk);
        check("load_insn_pulses", we_cyc.size(), 3);
        if (we_cyc.size() == 3)
            check("load_insn_consecutive", we_cyc[2] - we_cyc[0], 2);
        check("load_insn_busy_end", busy, 0);
        check("load_insn_drained", exp_q.size(), 0);

        // LOAD_DATA N=0: base word returns to IDLE, no strobes
        we_cyc.delete();
        send_word(32'h2000_0000);
        send_word(32'h0000_0040);
        idle();
        check("load0_state", fsm_state, ST_IDLE);
        check("load0_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("load0_no_we", we_cyc.size(), 0);

        // RUN L=10: reset for RST_N cycles, then run exactly 10 cycles
        send_word(32'h3000_000A);
        idle();
        bad_rst = 0; bad_run = 0; bad_rdy = 0; run_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            exp_r = (i <= RST_N);
            exp_u = (i > RST_N) && (i <= RST_N + 10);
            if (core_reset !== exp_r) bad_rst++;
            if (core_run !== exp_u) bad_run++;
            if (in_ready !== !exp_r) bad_rdy++;
            if (core_run === 1'b1) run_seen++;
            @(negedge clk);
        end
        check("run10_reset_pattern_bad_cycles", bad_rst, 0);
        check("run10_run_pattern_bad_cycles", bad_run, 0);
        check("run10_ready_pattern_bad_cycles", bad_rdy, 0);
        check("run10_run_cycles", run_seen, 10);
        check("run10_idle", fsm_state, ST_IDLE);
        check("run10_core_reset_low", core_reset, 0);

        // RUN L=0, HALT after 25 run cycles
        send_word(32'h3000_0000);
        idle();
        repeat (RST_N + 25) @(negedge clk);
        check("unl_running", core_run, 1);
        send_word(32'h4000_0000);
        idle();
        check("unl_halt_run", core_run, 0);
        check("unl_halt_err", err, 0);
        check("unl_halt_busy", busy, 0);

        // HALT accepted in the same cycle the limit expires
        send_word(32'h3000_0003);
        idle();
        repeat (6) @(negedge clk);
        check("race_last_run_cycle", core_run, 1);
        send_word(32'h4000_0000);
        idle();
        check("race_run", core_run, 0);
        check("race_err", err, 0);
        check("race_state", fsm_state, ST_IDLE);
        repeat (2) @(negedge clk);
        check("race_still_stopped", core_run, 0);

        // LOAD while running: consumed, err set, no write
        we_cyc.delete();
        send_word(32'h3000_0000);
        idle();
        repeat (RST_N + 2) @(negedge clk);
        send_word(32'h1000_0002);
        send_word(32'hDEAD_BEEF);
        idle();
        check("runload_err", err, 1);
        check("runload_still_run", core_run, 1);
        check("runload_state", fsm_state, ST_RUN);
        send_word(32'h4000_0000);
        idle();
        check("runload_halt_err_kept", err, 1);
        check("runload_halted", core_run, 0);
        send_word(32'h0000_0000);
        idle();
        check("runload_nop_clear", err, 0);
        check("runload_no_we", we_cyc.size(), 0);

        // reset asserted during word 2 of 4
        send_word(32'h2000_0004);
        send_word(32'h0000_0200);
        send_payload(1'b1, 32'h200, 32'h1111_0000);
        in_data = 32'h2222_0000;
        #2 reset = 1'b0;
        idle();
        #1 check_reset_values("abort");
        @(negedge clk);
        check("abort_held_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);
        send_word(32'h2000_0002);
        send_word(32'h0000_0300);
        send_payload(1'b1, 32'h300, 32'h3333_0001);
        send_payload(1'b1, 32'h304, 32'h4444_0002);
        idle();
        repeat (3) @(negedge clk);
        check("reload_busy", busy, 0);
        check("reload_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test expected finish before 200000");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
